// File: rtl/video_ram_pkg.sv
// Shared types and constants for the video RAM scan-out block.
package video_ram_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN
  } scan_state_t;

  localparam int RD_LATENCY = 2;

  // Tag width for a counter over n values; never narrower than one bit.
  function automatic int tag_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/video_ram_scanout_if.sv
// Host write bus into the video RAM (valid/ready handshake).
interface video_ram_scanout_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 11
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/video_ram_dpram.sv
// Simple dual-port RAM with registered read. With VIDEO_RAM_BYPASS_EN defined a
// same-address write is forwarded to the read; otherwise the read is read-first.
module video_ram_dpram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_q
);
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
`ifdef VIDEO_RAM_BYPASS_EN
    if (rd_en) rd_q <= (wr_en && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
`else
    if (rd_en) rd_q <= mem[rd_addr];
`endif
  end
endmodule

// File: rtl/video_ram_scanout.sv
// Video RAM with host write port and raster scan engine (2-cycle read pipeline).
// Collision forwarding is enabled by defining VIDEO_RAM_BYPASS_EN.
module video_ram_scanout
  import video_ram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 11,
  parameter int COLS   = 80,
  parameter int ROWS   = 25,
  parameter int BASE   = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  video_ram_scanout_if.slave          wr,
  input  logic                        scan_start,
  input  logic                        scan_en,
  output logic                        busy,
  output logic                        rd_valid,
  output logic [DATA_W-1:0]           rd_data,
  output logic [tag_width(COLS)-1:0]  rd_col,
  output logic [tag_width(ROWS)-1:0]  rd_row,
  output logic                        line_end,
  output logic                        frame_end
);
  localparam int COL_W = tag_width(COLS);
  localparam int ROW_W = tag_width(ROWS);

  scan_state_t       state_reg, state_next;
  logic [COL_W-1:0]  col_reg, col_next;
  logic [ROW_W-1:0]  row_reg, row_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [1:0]        drain_reg, drain_next;
  logic              issue, last_col, last_row, wr_en;
  logic [DATA_W-1:0] ram_q;

  logic              s1_valid_reg, s1_line_reg, s1_frame_reg;
  logic [COL_W-1:0]  s1_col_reg;
  logic [ROW_W-1:0]  s1_row_reg;

  assign wr.wr_ready = reset;
  assign wr_en       = wr.wr_valid & wr.wr_ready;
  assign last_col    = (col_reg == COL_W'(COLS - 1));
  assign last_row    = (row_reg == ROW_W'(ROWS - 1));
  assign busy        = (state_reg != IDLE);

  video_ram_dpram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr.wr_addr),
    .wr_data (wr.wr_data),
    .rd_en   (issue),
    .rd_addr (addr_reg),
    .rd_q    (ram_q)
  );

  always_comb begin
    state_next = state_reg;
    col_next   = col_reg;
    row_next   = row_reg;
    addr_next  = addr_reg;
    drain_next = drain_reg;
    issue      = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (scan_start) begin
          state_next = SCAN;
          col_next   = '0;
          row_next   = '0;
          addr_next  = ADDR_W'(BASE);
        end
      end
      SCAN: begin
        if (scan_en) begin
          issue     = 1'b1;
          addr_next = addr_reg + ADDR_W'(1);
          if (last_col) begin
            col_next = '0;
            if (last_row) begin
              state_next = DRAIN;
              drain_next = '0;
            end else begin
              row_next = row_reg + ROW_W'(1);
            end
          end else begin
            col_next = col_reg + COL_W'(1);
          end
        end
      end
      DRAIN: begin
        // Hold off IDLE until the last issued read has left the output register.
        if (drain_reg == 2'(RD_LATENCY - 1)) state_next = IDLE;
        else                                  drain_next = drain_reg + 2'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      col_reg   <= '0;
      row_reg   <= '0;
      addr_reg  <= '0;
      drain_reg <= '0;
    end else begin
      state_reg <= state_next;
      col_reg   <= col_next;
      row_reg   <= row_next;
      addr_reg  <= addr_next;
      drain_reg <= drain_next;
    end
  end

  // Tags travel beside the RAM read so they line up with rd_data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_reg <= 1'b0;
      s1_line_reg  <= 1'b0;
      s1_frame_reg <= 1'b0;
      s1_col_reg   <= '0;
      s1_row_reg   <= '0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
      rd_col       <= '0;
      rd_row       <= '0;
      line_end     <= 1'b0;
      frame_end    <= 1'b0;
    end else begin
      s1_valid_reg <= issue;
      s1_line_reg  <= issue & last_col;
      s1_frame_reg <= issue & last_col & last_row;
      if (issue) begin
        s1_col_reg <= col_reg;
        s1_row_reg <= row_reg;
      end
      rd_valid  <= s1_valid_reg;
      line_end  <= s1_valid_reg & s1_line_reg;
      frame_end <= s1_valid_reg & s1_frame_reg;
      if (s1_valid_reg) begin
        rd_data <= ram_q;
        rd_col  <= s1_col_reg;
        rd_row  <= s1_row_reg;
      end
    end
  end
endmodule

// File: tb/tb_video_ram_scanout.sv
// Directed bench: 4x2 grid at BASE 0 plus a 4x1 grid at BASE 2046 (wrap case).
module tb_video_ram_scanout;
  localparam int AW = 11;

`ifdef VIDEO_RAM_BYPASS_EN
  localparam logic [7:0] COLL_EXP = 8'hAA;
`else
  localparam logic [7:0] COLL_EXP = 8'h55;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  video_ram_scanout_if #(.DATA_W(8), .ADDR_W(AW)) bus_a ();
  video_ram_scanout_if #(.DATA_W(8), .ADDR_W(AW)) bus_b ();

  logic       start_a, en_a, busy_a, valid_a, line_a, frame_a;
  logic [7:0] data_a;
  logic [1:0] col_a;
  logic [0:0] row_a;
  logic       start_b, en_b, busy_b, valid_b, line_b, frame_b;
  logic [7:0] data_b;
  logic [1:0] col_b;
  logic [0:0] row_b;

  logic [7:0] mem_a [8];
  int tests = 0;
  int fails = 0;

  video_ram_scanout #(.DATA_W(8), .ADDR_W(AW), .COLS(4), .ROWS(2), .BASE(0)) dut_a (
    .clk(clk), .reset(reset), .wr(bus_a), .scan_start(start_a), .scan_en(en_a),
    .busy(busy_a), .rd_valid(valid_a), .rd_data(data_a), .rd_col(col_a), .rd_row(row_a),
    .line_end(line_a), .frame_end(frame_a)
  );

  video_ram_scanout #(.DATA_W(8), .ADDR_W(AW), .COLS(4), .ROWS(1), .BASE(2046)) dut_b (
    .clk(clk), .reset(reset), .wr(bus_b), .scan_start(start_b), .scan_en(en_b),
    .busy(busy_b), .rd_valid(valid_b), .rd_data(data_b), .rd_col(col_b), .rd_row(row_b),
    .line_end(line_b), .frame_end(frame_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_a(input logic [AW-1:0] a, input logic [7:0] d);
    bus_a.wr_valid = 1'b1; bus_a.wr_addr = a; bus_a.wr_data = d;
    tick();
    bus_a.wr_valid = 1'b0;
    if (a < 11'd8) mem_a[a[2:0]] = d;
  endtask

  task automatic write_b(input logic [AW-1:0] a, input logic [7:0] d);
    bus_b.wr_valid = 1'b1; bus_b.wr_addr = a; bus_b.wr_data = d;
    tick();
    bus_b.wr_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] got;
    tick();
    reset = 1'b0;
    tick(); tick();
    got = {bus_a.wr_ready, busy_a, valid_a, data_a, col_a, row_a, line_a, frame_a};
    tests++;
    if (got !== 16'h0) begin fails++; $display("FAIL reset_outputs: got %h want 0000", got); end
    reset = 1'b1;
    tick();
    tests++;
    if (bus_a.wr_ready !== 1'b1) begin fails++; $display("FAIL reset_wr_ready: got %b want 1", bus_a.wr_ready); end
    tests++;
    if ({busy_a, valid_a} !== 2'b00) begin fails++; $display("FAIL reset_release_idle: got %b want 00", {busy_a, valid_a}); end
    $display("[TB] reset released");
  endtask

  // Full-speed frame of the 4x2 grid; shared by the plain and post-reset frames.
  task automatic test_frame(input string tag);
    logic [13:0] got, exp;
    int idx;
    start_a = 1'b1; en_a = 1'b1;
    tests++;
    if (busy_a !== 1'b0) begin fails++; $display("FAIL %s_busy_pre: got %b want 0", tag, busy_a); end
    tick();
    start_a = 1'b0;
    for (int t = 1; t <= 11; t++) begin
      if (t >= 3 && t <= 10) begin
        idx = t - 3;
        got = {valid_a, data_a, col_a, row_a, line_a, frame_a};
        exp = {1'b1, mem_a[idx], 2'(idx % 4), 1'(idx / 4), 1'(idx % 4 == 3), 1'(idx == 7)};
        $display("[TB] %s beat col=%0d row=%0d data=%02h line=%b frame=%b", tag, col_a, row_a, data_a, line_a, frame_a);
      end else begin
        got = {valid_a, 11'h0, line_a, frame_a};
        exp = '0;
      end
      tests++;
      if (got !== exp) begin fails++; $display("FAIL %s_beat_t%0d: got %h want %h", tag, t, got, exp); end
      tests++;
      if (busy_a !== 1'(t <= 10)) begin fails++; $display("FAIL %s_busy_t%0d: got %b want %b", tag, t, busy_a, t <= 10); end
      tick();
    end
    en_a = 1'b0;
  endtask

  task automatic test_scan_en();
    logic [15:0] pat;
    logic [13:0] got, exp;
    int iss [64];
    int n, last, idx;
    pat = 16'b1011_0100_1110_1101;
    n = 0; last = -1;
    for (int i = 0; i < 64; i++) iss[i] = -1;
    start_a = 1'b1; en_a = 1'b0;
    tick();
    start_a = 1'b0;
    for (int t = 1; t < 64; t++) begin
      en_a = (n < 8) ? pat[(t - 1) % 16] : 1'b0;
      if (t >= 3 && iss[t-2] >= 0) begin
        idx = iss[t-2];
        got = {valid_a, data_a, col_a, row_a, line_a, frame_a};
        exp = {1'b1, mem_a[idx], 2'(idx % 4), 1'(idx / 4), 1'(idx % 4 == 3), 1'(idx == 7)};
        $display("[TB] scan_en beat col=%0d row=%0d data=%02h", col_a, row_a, data_a);
      end else begin
        got = {valid_a, 11'h0, line_a, frame_a};
        exp = '0;
      end
      tests++;
      if (got !== exp) begin fails++; $display("FAIL scan_en_beat_t%0d: got %h want %h", t, got, exp); end
      tests++;
      if (busy_a !== 1'(last < 0 || t <= last + 2)) begin
        fails++; $display("FAIL scan_en_busy_t%0d: got %b want %b", t, busy_a, last < 0 || t <= last + 2);
      end
      if (last >= 0 && t == last + 3) break;
      if (en_a && n < 8) begin
        iss[t] = n;
        n++;
        if (n == 8) last = t;
      end
      tick();
    end
    en_a = 1'b0;
    tests++;
    if (n != 8) begin fails++; $display("FAIL scan_en_issued: got %0d want 8", n); end
  endtask

  task automatic test_wrap();
    logic [13:0] got, exp;
    int idx;
    write_b(11'd2045, 8'hEE);
    write_b(11'd2046, 8'hA0);
    write_b(11'd2047, 8'hA1);
    write_b(11'd0,    8'hA2);
    write_b(11'd1,    8'hA3);
    write_b(11'd2,    8'hEF);
    start_b = 1'b1; en_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int t = 1; t <= 7; t++) begin
      if (t >= 3 && t <= 6) begin
        idx = t - 3;
        got = {valid_b, data_b, col_b, row_b, line_b, frame_b};
        exp = {1'b1, 8'(8'hA0 + idx), 2'(idx), 1'b0, 1'(idx == 3), 1'(idx == 3)};
        $display("[TB] wrap beat col=%0d data=%02h", col_b, data_b);
      end else begin
        got = {valid_b, 11'h0, line_b, frame_b};
        exp = '0;
      end
      tests++;
      if (got !== exp) begin fails++; $display("FAIL wrap_beat_t%0d: got %h want %h", t, got, exp); end
      tests++;
      if (busy_b !== 1'(t <= 6)) begin fails++; $display("FAIL wrap_busy_t%0d: got %b want %b", t, busy_b, t <= 6); end
      tick();
    end
    en_b = 1'b0;
  endtask

  task automatic test_collision();
    logic [13:0] got, exp;
    write_a(11'd5, 8'h55);
    start_a = 1'b1; en_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int t = 1; t <= 11; t++) begin
      bus_a.wr_valid = (t == 6);
      bus_a.wr_addr  = 11'd5;
      bus_a.wr_data  = 8'hAA;
      if (t == 8) begin
        got = {valid_a, data_a, col_a, row_a, line_a, frame_a};
        exp = {1'b1, COLL_EXP, 2'd1, 1'b1, 1'b0, 1'b0};
        $display("[TB] collision beat col=%0d row=%0d data=%02h", col_a, row_a, data_a);
        tests++;
        if (got !== exp) begin fails++; $display("FAIL collision_beat: got %h want %h", got, exp); end
      end
      tick();
    end
    bus_a.wr_valid = 1'b0;
    en_a = 1'b0;
    mem_a[5] = 8'hAA;
  endtask

  task automatic test_reset_mid();
    logic [15:0] got;
    start_a = 1'b1; en_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick(); tick(); tick();
    reset = 1'b0;
    tick();
    got = {bus_a.wr_ready, busy_a, valid_a, data_a, col_a, row_a, line_a, frame_a};
    tests++;
    if (got !== 16'h0) begin fails++; $display("FAIL midreset_outputs: got %h want 0000", got); end
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++;
      if ({busy_a, valid_a, line_a, frame_a} !== 4'b0) begin
        fails++; $display("FAIL midreset_stale_%0d: got %b want 0000", k, {busy_a, valid_a, line_a, frame_a});
      end
    end
    en_a = 1'b0;
    test_frame("after_reset");
  endtask

  initial begin
    bus_a.wr_valid = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0;
    bus_b.wr_valid = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0;
    start_a = 1'b0; en_a = 1'b0; start_b = 1'b0; en_b = 1'b0;
    test_reset();
    for (int i = 0; i < 8; i++) write_a(AW'(i), 8'(8'h10 + i));
    test_frame("frame");
    test_scan_en();
    test_wrap();
    test_collision();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
